// File: rtl/arb_rr_lock_pkg.sv
// Shared constants, FSM encoding and index helper for the per-output-port
// switch allocator (arb_rr_lock) and its round-robin picker.
//   NPORT      : number of router inputs (N, E, S, W, Eject)
//   CRED_DEPTH : downstream buffer depth in flits = initial/maximum credits
//   CW         : credit counter width
//   IW         : width of an input index (ptr, owner, winner)
package arb_rr_lock_pkg;

  localparam int NPORT      = 5;
  localparam int CRED_DEPTH = 4;
  localparam int CW         = 3;
  localparam int IW         = 3;

  // Router input indices
  localparam int P_N  = 0;
  localparam int P_E  = 1;
  localparam int P_S  = 2;
  localparam int P_W  = 3;
  localparam int P_EJ = 4;

  // FSM encoding
  localparam logic S_IDLE   = 1'b0;
  localparam logic S_LOCKED = 1'b1;

  typedef enum logic {
    ST_IDLE   = S_IDLE,
    ST_LOCKED = S_LOCKED
  } state_t;

  // (idx + 1) mod NPORT for an input index
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    return (idx == IW'(NPORT - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/arb_rr_lock_if.sv
// Handshake bundle between the router inputs/downstream credit path and one
// output-port allocator.
//   req, tail, multab_ct : per-input request, tail marker and allocation bar
//   credit_in            : one-cycle pulse, downstream freed one slot
//   grt                  : one-hot-or-zero grant (flit moves this cycle)
//   locked, owner        : port held by an in-flight packet and its holder
//   credits, credit_err  : credit count and sticky overflow flag
// master = router side driving requests, slave = allocator.
interface arb_rr_lock_if;
  import arb_rr_lock_pkg::*;

  logic [NPORT-1:0] req;
  logic [NPORT-1:0] tail;
  logic [NPORT-1:0] multab_ct;
  logic             credit_in;
  logic [NPORT-1:0] grt;
  logic             locked;
  logic [IW-1:0]    owner;
  logic [CW-1:0]    credits;
  logic             credit_err;

  modport master (
    output req, tail, multab_ct, credit_in,
    input  grt, locked, owner, credits, credit_err
  );

  modport slave (
    input  req, tail, multab_ct, credit_in,
    output grt, locked, owner, credits, credit_err
  );

endinterface

// File: rtl/arb_rr_lock_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of elig when
// scanning ptr, ptr+1, ... wrapping modulo NPORT.
//   elig    : eligible inputs
//   ptr     : index with highest priority this cycle
//   win_oh  : one-hot winner (zero when nothing is eligible)
//   win_idx : winner index (0 when nothing is eligible)
//   any     : at least one input is eligible
module arb_rr_lock_rr_pick
  import arb_rr_lock_pkg::*;
(
  input  logic [NPORT-1:0] elig,
  input  logic [IW-1:0]    ptr,
  output logic [NPORT-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             any
);

  localparam int DW = 2 * NPORT;
  localparam int PW = $clog2(DW);

  logic [NPORT-1:0] hi_mask;
  logic [DW-1:0]    dbl;
  logic [PW-1:0]    pos;
  logic             found;

  // Lower half keeps only bits at or above ptr; upper half is the full vector,
  // so a plain lowest-bit scan over the doubled vector gives the wrapped winner.
  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_mask
      assign hi_mask[gi] = (IW'(gi) >= ptr);
    end
  endgenerate

  assign dbl = {elig, elig & hi_mask};
  assign any = |elig;

  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < DW; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        pos   = PW'(k);
      end
    end
  end

  assign win_idx = (pos >= PW'(NPORT)) ? IW'(pos - PW'(NPORT)) : IW'(pos);

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_oh
      assign win_oh[gi] = any && (win_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/arb_rr_lock.sv
// Per-output-port switch allocator for the wormhole router. Round-robin picks
// a new packet owner among the inputs; the port then stays locked to that
// owner until its tail flit passes. Every grant is gated by a downstream
// credit counter. Grant is combinational from registered state and inputs.
//   clk  : clock
//   rst_ : synchronous reset, active-low
//   bus  : arb_rr_lock_if slave (req/tail/multab_ct/credit_in in,
//          grt/locked/owner/credits/credit_err out)
module arb_rr_lock
  import arb_rr_lock_pkg::*;
(
  input  logic           clk,
  input  logic           rst_,
  arb_rr_lock_if.slave   bus
);

  state_t           state_reg;
  logic [IW-1:0]    ptr_reg;
  logic [IW-1:0]    owner_reg;
  logic [CW-1:0]    credits_reg;
  logic             credit_err_reg;

  logic             gate;
  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic             any;
  logic [NPORT-1:0] owner_oh;
  logic [NPORT-1:0] grant;
  logic             tail_hit;
  logic             dec;
  logic             inc;

  assign gate = (credits_reg != '0);
  assign elig = bus.req & ~bus.multab_ct;

  arb_rr_lock_rr_pick u_pick (
    .elig    (elig),
    .ptr     (ptr_reg),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_owner
      assign owner_oh[gi] = (owner_reg == IW'(gi));
    end
  endgenerate

  // Once locked, only the owner may move; multab_ct no longer applies to it.
  always_comb begin
    grant = '0;
    if (rst_ && gate) begin
      case (state_reg)
        ST_IDLE:   grant = any ? win_oh : '0;
        ST_LOCKED: grant = owner_oh & bus.req;
        default:   grant = '0;
      endcase
    end
  end

  assign tail_hit = |(grant & bus.tail);
  assign dec      = |grant;
  assign inc      = bus.credit_in;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= IW'(P_EJ);
      owner_reg      <= '0;
      credits_reg    <= CW'(CRED_DEPTH);
      credit_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (dec) begin
            if (tail_hit) begin
              ptr_reg <= wrap_inc(win_idx);
            end else begin
              state_reg <= ST_LOCKED;
              owner_reg <= win_idx;
            end
          end
        end
        ST_LOCKED: begin
          // Release only; a new head is allocated in the following cycle.
          if (dec && tail_hit) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= wrap_inc(owner_reg);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (dec && !inc) begin
        credits_reg <= credits_reg - 1'b1;
      end else if (inc && !dec) begin
        if (credits_reg == CW'(CRED_DEPTH)) begin
          credit_err_reg <= 1'b1;
        end else begin
          credits_reg <= credits_reg + 1'b1;
        end
      end
    end
  end

  assign bus.grt        = grant;
  assign bus.locked     = (state_reg == ST_LOCKED);
  assign bus.owner      = owner_reg;
  assign bus.credits    = credits_reg;
  assign bus.credit_err = credit_err_reg;

endmodule

// File: tb/tb_arb_rr_lock.sv
module tb_arb_rr_lock;

  logic clk;
  logic rst_;

  arb_rr_lock_if bus ();

  arb_rr_lock dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0] grt;
    logic       lk;
    int         own;
    int         cr;
    logic       err;
    bit         full;
  } sb_t;

  sb_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_valid  = 0;
  bit m_locked = 0;
  int m_ptr    = 4;
  int m_owner  = 0;
  int m_cred   = 4;
  bit m_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push the model's expectation, advance model.
  task automatic step(input logic rn, input logic [4:0] r, input logic [4:0] t,
                      input logic [4:0] m, input logic c);
    int w;
    logic [4:0] eg;
    sb_t it;
    @(posedge clk);
    #1;
    rst_ = rn;
    bus.req = r;
    bus.tail = t;
    bus.multab_ct = m;
    bus.credit_in = c;
    w = -1;
    eg = '0;
    if (rn && m_cred != 0) begin
      if (!m_locked) begin
        for (int k = 0; k < 5; k++) begin
          int idx;
          idx = (m_ptr + k) % 5;
          if (w < 0 && r[idx] && !m[idx]) w = idx;
        end
      end else if (r[m_owner]) begin
        w = m_owner;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    it.grt = eg; it.lk = m_locked; it.own = m_owner;
    it.cr = m_cred; it.err = m_err; it.full = m_valid;
    sb_q.push_back(it);
    $display("step rst_=%0b req=%02h tail=%02h mask=%02h cin=%0b exp_grt=%02h",
             rn, r, t, m, c, eg);
    if (!rn) begin
      m_locked = 0; m_ptr = 4; m_owner = 0; m_cred = 4; m_err = 0; m_valid = 1;
    end else begin
      if (w >= 0) begin
        if (!m_locked) begin
          if (t[w]) m_ptr = (w + 1) % 5;
          else begin m_locked = 1; m_owner = w; end
        end else if (t[w]) begin
          m_locked = 0;
          m_ptr = (w + 1) % 5;
        end
      end
      if (w >= 0 && !c) m_cred--;
      else if (c && w < 0) begin
        if (m_cred == 4) m_err = 1;
        else m_cred++;
      end
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: pop and compare on the falling edge, check invariants.
  initial begin
    sb_t it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        check_eq("grt", bus.grt, it.grt);
        if (it.full) begin
          check_eq("locked", bus.locked, it.lk);
          check_eq("owner", bus.owner, it.own);
          check_eq("credits", bus.credits, it.cr);
          check_eq("credit_err", bus.credit_err, it.err);
        end
      end
      if (rst_ === 1'b1) begin
        check_eq("onehot0", $onehot0(bus.grt), 1);
        check_eq("grt_needs_req", bus.grt & ~bus.req, 0);
      end
    end
  end

  int order [6] = '{4, 0, 1, 2, 3, 4};

  initial begin
    rst_ = 1'b0;
    bus.req = '0; bus.tail = '0; bus.multab_ct = '0; bus.credit_in = 1'b0;

    // 1 reset
    step(0, 5'h1F, 5'h00, 5'h00, 0); check_eq("rst_grt0", bus.grt, 0);
    step(0, 5'h1F, 5'h00, 5'h00, 0); check_eq("rst_grt1", bus.grt, 0);
    step(1, 5'h00, 5'h00, 5'h00, 0);
    check_eq("rst_credits", bus.credits, 4);
    check_eq("rst_locked", bus.locked, 0);

    // 2 round-robin fairness, single-flit packets
    for (int i = 0; i < 6; i++) begin
      step(1, 5'h1F, 5'h1F, 5'h00, 1);
      check_eq("rr_order", bus.grt, 32'(1) << order[i]);
      check_eq("rr_credits_ge3", bus.credits >= 3, 1);
    end

    // 3 lock on input 1 with a bubble
    step(1, 5'h01, 5'h01, 5'h00, 1); check_eq("lk_pre", bus.grt, 5'h01);
    step(1, 5'h1F, 5'h00, 5'h00, 1); check_eq("lk_head", bus.grt, 5'h02);
    step(1, 5'h1F, 5'h00, 5'h00, 1); check_eq("lk_body1", bus.grt, 5'h02);
    step(1, 5'h1D, 5'h00, 5'h00, 0); check_eq("lk_bubble", bus.grt, 5'h00);
    check_eq("lk_bubble_locked", bus.locked, 1);
    step(1, 5'h1F, 5'h00, 5'h00, 1); check_eq("lk_body2", bus.grt, 5'h02);
    step(1, 5'h1F, 5'h02, 5'h00, 1); check_eq("lk_tail", bus.grt, 5'h02);
    step(1, 5'h1F, 5'h1F, 5'h00, 1); check_eq("lk_next", bus.grt, 5'h04);

    // 4 credit stall on a 6-flit packet from input 3
    for (int i = 0; i < 4; i++) begin
      step(1, 5'h08, 5'h00, 5'h00, 0); check_eq("cs_grant", bus.grt, 5'h08);
    end
    step(1, 5'h08, 5'h00, 5'h00, 0);
    check_eq("cs_stall", bus.grt, 5'h00);
    check_eq("cs_zero", bus.credits, 0);
    step(1, 5'h08, 5'h00, 5'h00, 1); check_eq("cs_stall_cin", bus.grt, 5'h00);
    step(1, 5'h08, 5'h00, 5'h00, 0); check_eq("cs_one_more", bus.grt, 5'h08);
    step(1, 5'h08, 5'h00, 5'h00, 0); check_eq("cs_stall2", bus.grt, 5'h00);
    step(1, 5'h08, 5'h00, 5'h00, 1);
    step(1, 5'h08, 5'h08, 5'h00, 1);
    check_eq("cs_both_grt", bus.grt, 5'h08);
    check_eq("cs_both_cr_before", bus.credits, 1);
    step(1, 5'h00, 5'h00, 5'h00, 1);
    check_eq("cs_both_cr_after", bus.credits, 1);
    step(1, 5'h00, 5'h00, 5'h00, 1);
    step(1, 5'h00, 5'h00, 5'h00, 1);

    // 5 multicast mask
    step(1, 5'h11, 5'h00, 5'h10, 1); check_eq("mask_pick", bus.grt, 5'h01);
    step(1, 5'h11, 5'h00, 5'h01, 1); check_eq("mask_owner", bus.grt, 5'h01);
    step(1, 5'h11, 5'h01, 5'h01, 1); check_eq("mask_tail", bus.grt, 5'h01);

    // 6 credit error and reset mid-packet
    step(1, 5'h00, 5'h00, 5'h00, 1);
    check_eq("err_before", bus.credit_err, 0);
    step(1, 5'h00, 5'h00, 5'h00, 0); check_eq("err_set", bus.credit_err, 1);
    step(1, 5'h00, 5'h00, 5'h00, 0); check_eq("err_sticky", bus.credit_err, 1);
    step(1, 5'h02, 5'h00, 5'h00, 0); check_eq("mid_head", bus.grt, 5'h02);
    step(1, 5'h02, 5'h00, 5'h00, 0); check_eq("mid_locked", bus.locked, 1);
    step(0, 5'h02, 5'h00, 5'h00, 0); check_eq("mid_rst_grt", bus.grt, 0);
    step(1, 5'h00, 5'h00, 5'h00, 0);
    check_eq("post_locked", bus.locked, 0);
    check_eq("post_credits", bus.credits, 4);
    check_eq("post_err", bus.credit_err, 0);
    step(1, 5'h1F, 5'h1F, 5'h00, 0); check_eq("post_ptr4", bus.grt, 5'h10);

    step(1, 5'h00, 5'h00, 5'h00, 0);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
